mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. Performs loads and stores against a handshaked data-memory bus and stalls upstream stages while an access is outstanding. Formats load data by size, offset and sign, and forwards the result, destination register and control byte. The MEM/WB register has no enable, so stall cycles present a bubble (control zero).

Parameters:
TIMEOUT, 16, cycles in BUSY without mem_ack before the access is aborted (legal range 1..255).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
valid_EX  in  1  EX/MEM holds a live instruction
control_EX  in  8  control byte from EX/MEM
alu_result  in  32  effective address, or the result for non-memory ops
store_data  in  32  rt value for stores
rd  in  5  destination register from EX/MEM
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
d2  out  32  signed result to MEM/WB
rd_MEM  out  5  destination register to MEM/WB
control_MEM  out  8  control byte to MEM/WB
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  bus completion, 1-cycle pulse
mem_rdata  in  32  read data, valid with mem_ack
misalign  out  1  1-cycle pulse, misaligned access dropped
bus_err  out  1  1-cycle pulse, access timed out

Behaviour:
- Control byte bits:
  - [0] mem_read, [1] mem_write, [2] reg_write, [3] mem_to_reg.
  - [5:4] size: 00 byte, 01 half, 10 word, 11 treated as word.
  - [6] signed load, [7] pass-through.
- Memory op: valid_EX & (c[0]|c[1]). c[0] and c[1] both set is treated as a load.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Reset (async, reset=0), applied immediately:
  - State IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_buf, timeout counter, misalign, bus_err all 0.
  - Combinational outputs follow the IDLE rules below.
- IDLE:
  - Non-memory op or !valid_EX: stall=0; d2=alu_result, rd_MEM=rd, control_MEM=valid_EX?control_EX:0 (combinational pass-through).
  - Aligned memory op: stall=1, control_MEM=0. At the clock edge, register mem_req=1, mem_we=c[1], mem_addr, mem_be and mem_wdata; clear counter; go to BUSY.
  - Misaligned memory op: stall=0, control_MEM=0. Register a misalign pulse. No bus activity; the instruction retires as a bubble.
- BUSY:
  - stall=1, control_MEM=0. Bus outputs are held stable while mem_req=1.
  - mem_ack=1: capture the formatted load into load_buf; mem_req and mem_be go to 0; go to DONE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without ack: drop mem_req, pulse bus_err, set an internal abort flag, go to DONE.
- DONE (one cycle):
  - stall=0; rd_MEM=rd.
  - Load: d2=load_buf, control_MEM=control_EX. Store: d2=alu_result, control_MEM=control_EX.
  - If aborted: control_MEM=0.
  - Next state is IDLE. The upstream stages advance at this edge, so a new instruction is evaluated in IDLE.
- Latency: a memory op with mem_ack in the first BUSY cycle costs 2 stall cycles; each extra wait cycle adds one.
- Load formatting uses offset o=addr[1:0]:
  - Byte: mem_rdata[8o+7:8o].
  - Half: mem_rdata[16*o[1]+15:16*o[1]].
  - Sign-extend if c[6], else zero-extend; word loads are unmodified.
- Store formatting:
  - Byte: be=4'b0001<<o, wdata=replicate store_data[7:0] x4.
  - Half: be=o[1]?1100:0011, wdata=replicate store_data[15:0] x2.
  - Word: be=1111, wdata=store_data.
- mem_ack outside BUSY is ignored.
- mem_ack arriving in the same cycle as the timeout: the ack wins, and there is no bus_err.
- valid_EX dropping while stalled is not legal (upstream is frozen); no behaviour is defined for it.

Test Plan:
1. Reset low mid-BUSY (mem_req=1) -> mem_req=0 immediately without a clock edge, stall=0 in IDLE; after release, a non-memory op with alu_result=0x0000_0007, rd=5, control=0x04 -> same cycle d2=7, rd_MEM=5, control_MEM=0x04, stall=0.
2. Signed byte load, addr=0x103, control=0x49, mem_rdata=0x80xx_xxxx, ack on first BUSY cycle -> mem_addr=0x100, mem_be=0 during read, stall high 2 cycles, DONE d2=0xFFFF_FF80, control_MEM=0x49.
3. Halfword store, addr=0x102, store_data=0x1234_ABCD, control=0x12 -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, d2=0x102 in DONE.
4. Word load, addr=0x201 -> misalign pulse 1 cycle, mem_req never set, stall=0, control_MEM=0.
5. Word load, mem_ack withheld, TIMEOUT=16 -> mem_req held 16 BUSY cycles then drops, bus_err pulse, DONE control_MEM=0; variant with ack on the final BUSY cycle -> normal completion, no bus_err.
6. Back-to-back loads with ack after 3 wait cycles each -> each DONE delivers the correct formatted data; no duplicate request for the same instruction.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Memory stage of the 5-stage pipeline (EX/MEM -> MEM/WB). Issues loads and
//   stores on a req/ack data bus, holds the upstream stages with `stall` while
//   an access is outstanding, and formats load data by size, offset and sign.
//   MEM/WB has no enable, so every stall cycle presents a bubble (control 0).
//
// Bus handshake: mem_req rises with mem_we/mem_addr/mem_be/mem_wdata and all of
//   them stay stable while mem_req=1. The slave completes the access with a
//   single-cycle mem_ack, and mem_rdata is valid in that cycle. mem_ack outside
//   an outstanding access is ignored. An access with no ack for TIMEOUT BUSY
//   cycles is abandoned (bus_err pulse, result retires as a bubble).
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   valid_EX, control_EX    live flag and control byte from EX/MEM
//   alu_result, store_data  address (or non-memory result), store value
//   rd                      destination register
//   stall                   freeze PC, IF/ID, ID/EX, EX/MEM
//   d2, rd_MEM, control_MEM result, destination, control byte to MEM/WB
//   mem_*                   data-memory bus
//   misalign, bus_err       one-cycle error pulses
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_EX,
    input  logic [7:0]  control_EX,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic [31:0] d2,
    output logic [4:0]  rd_MEM,
    output logic [7:0]  control_MEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        aborted_q;
    logic [31:0] load_buf;

    // Instruction decode. Both mem_read and mem_write set is a load.
    logic        is_load, is_store, mem_op, mis;
    logic [1:0]  size, off;
    logic        sz_byte, sz_half, sz_word;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt, load_fmt;
    logic [7:0]  lb;
    logic [15:0] lh;

    assign is_load  = control_EX[0];
    assign is_store = control_EX[1] & ~control_EX[0];
    assign mem_op   = valid_EX & (control_EX[0] | control_EX[1]);
    assign size     = control_EX[5:4];
    assign off      = alu_result[1:0];
    assign sz_byte  = (size == 2'b00);
    assign sz_half  = (size == 2'b01);
    assign sz_word  = size[1];          // 10 and 11 are both word
    assign mis      = (sz_half & off[0]) | (sz_word & (off != 2'b00));

    always_comb begin
        be_fmt    = 4'b0000;
        wdata_fmt = store_data;
        if (sz_byte) begin
            wdata_fmt = {4{store_data[7:0]}};
            be_fmt    = 4'b0001 << off;
        end else if (sz_half) begin
            wdata_fmt = {2{store_data[15:0]}};
            be_fmt    = off[1] ? 4'b1100 : 4'b0011;
        end else begin
            be_fmt    = 4'b1111;
        end
        // Reads are whole-word; lanes are picked on the way back.
        if (!is_store) be_fmt = 4'b0000;
    end

    always_comb begin
        case (off)
            2'd0:    lb = mem_rdata[7:0];
            2'd1:    lb = mem_rdata[15:8];
            2'd2:    lb = mem_rdata[23:16];
            default: lb = mem_rdata[31:24];
        endcase
        lh = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (sz_byte)
            load_fmt = control_EX[6] ? {{24{lb[7]}}, lb} : {24'b0, lb};
        else if (sz_half)
            load_fmt = control_EX[6] ? {{16{lh[15]}}, lh} : {16'b0, lh};
        else
            load_fmt = mem_rdata;
    end

    // Next state and MEM/WB-facing outputs.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        d2          = alu_result;
        rd_MEM      = rd;
        control_MEM = valid_EX ? control_EX : 8'h00;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    control_MEM = 8'h00;
                    if (!mis) begin
                        stall   = 1'b1;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall       = 1'b1;
                control_MEM = 8'h00;
                if (mem_ack || cnt_q == TO_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (is_load) d2 = load_buf;
                control_MEM = aborted_q ? 8'h00 : control_EX;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Bus registers, timeout counter, capture buffer and error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            load_buf  <= 32'h0;
            cnt_q     <= 8'h0;
            aborted_q <= 1'b0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_op && !mis) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {alu_result[31:2], 2'b00};
                        mem_be    <= be_fmt;
                        mem_wdata <= wdata_fmt;
                        cnt_q     <= 8'h0;
                        aborted_q <= 1'b0;
                    end else if (mem_op) begin
                        misalign  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (mem_ack) begin
                        load_buf <= load_fmt;
                        mem_req  <= 1'b0;
                        mem_be   <= 4'h0;
                    end else if (cnt_q == TO_LAST) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//   Drives instructions into mem_access_stage with a simple bus responder that
//   acks after a programmable number of wait cycles (or never). Expected MEM/WB
//   results are queued when an instruction is issued and popped when the stage
//   retires it.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clock, reset;
    logic        valid_EX;
    logic [7:0]  control_EX;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd;
    logic        stall;
    logic [31:0] d2;
    logic [4:0]  rd_MEM;
    logic [7:0]  control_MEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        misalign, bus_err;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid_EX    (valid_EX),
        .control_EX  (control_EX),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .rd          (rd),
        .stall       (stall),
        .d2          (d2),
        .rd_MEM      (rd_MEM),
        .control_MEM (control_MEM),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .misalign    (misalign),
        .bus_err     (bus_err)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_ctl_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- bus responder ----------------
    int          ack_wait = 0;
    logic        ack_en = 1'b0;
    logic [31:0] rdata_model = 32'h0;
    int          req_count = 0;

    initial begin
        int   wait_cnt;
        logic prev_req;
        wait_cnt  = 0;
        prev_req  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req && !prev_req) req_count++;
            prev_req = mem_req;
            if (!mem_req) begin
                wait_cnt = 0;
            end else if (ack_en) begin
                if (wait_cnt == ack_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_model;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- reference formatting ----------------
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] o,
                                               input logic [7:0] ctl);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[o*8 +: 8];
        h = rdata[o[1]*16 +: 16];
        case (ctl[5:4])
            2'b00:   return ctl[6] ? 32'(signed'(b)) : 32'(b);
            2'b01:   return ctl[6] ? 32'(signed'(h)) : 32'(h);
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] o, input logic [7:0] ctl);
        case (ctl[5:4])
            2'b00:   return 4'(4'b0001 << o);
            2'b01:   return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] s, input logic [7:0] ctl);
        case (ctl[5:4])
            2'b00:   return {s[7:0], s[7:0], s[7:0], s[7:0]};
            2'b01:   return {s[15:0], s[15:0]};
            default: return s;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Issue one aligned memory op and follow it until it retires.
    // wait_cycles < 0 means the responder never acks.
    task automatic mem_op(input string name, input logic [7:0] ctl, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int wait_cycles, input logic [31:0] exp_d2,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        logic [4:0] r;
        int         stalls, exp_stalls, req0, n;
        logic       first, is_st, exp_err;
        is_st      = ctl[1] & ~ctl[0];
        exp_err    = (wait_cycles < 0) || (wait_cycles >= TIMEOUT);
        exp_stalls = exp_err ? 1 + TIMEOUT : 2 + wait_cycles;
        r          = 5'($urandom_range(1, 31));
        if (!exp_err) exp_q.push_back(exp_d2);
        exp_ctl_q.push_back(exp_err ? 8'h00 : ctl);
        ack_en      = !exp_err;
        ack_wait    = wait_cycles;
        rdata_model = rdata;
        req0        = req_count;

        @(posedge clock); #1;
        valid_EX = 1'b1; control_EX = ctl; alu_result = addr; store_data = sdata; rd = r;
        @(negedge clock);
        check({name, ".issue_stall"}, 32'(stall), 32'd1);
        check({name, ".issue_ctl"}, 32'(control_MEM), 32'h0);
        stalls = 1;
        first  = 1'b1;
        n      = 0;
        while (n < 64) begin
            @(negedge clock);
            if (!stall) break;
            if (first) begin
                check({name, ".req"}, 32'(mem_req), 32'd1);
                check({name, ".addr"}, mem_addr, {addr[31:2], 2'b00});
                check({name, ".we"}, 32'(mem_we), 32'(is_st));
                check({name, ".be"}, 32'(mem_be), 32'(exp_be));
                if (is_st) check({name, ".wdata"}, mem_wdata, exp_wdata);
                first = 1'b0;
            end
            stalls++;
            n++;
        end
        check({name, ".done_wait"}, 32'(stall), 32'd0);
        check({name, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({name, ".control"}, 32'(control_MEM), 32'(exp_ctl_q.pop_front()));
        if (!exp_err) check({name, ".d2"}, d2, exp_q.pop_front());
        check({name, ".rd"}, 32'(rd_MEM), 32'(r));
        check({name, ".bus_err"}, 32'(bus_err), 32'(exp_err));
        check({name, ".req_after"}, 32'(mem_req), 32'd0);
        check({name, ".req_count"}, 32'(req_count - req0), 32'd1);
        ack_en = 1'b0;
    endtask

    task automatic go_idle();
        @(posedge clock); #1;
        valid_EX = 1'b0; control_EX = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   req0;
        logic [7:0]  ctl;
        logic [31:0] addr, sd, rdv;
        logic [1:0]  sz, o;
        logic        st;
        int          w;

        reset = 1'b0; valid_EX = 1'b0; control_EX = 8'h00;
        alu_result = 32'h0; store_data = 32'h0; rd = 5'd0;
        repeat (3) @(negedge clock);
        check("rst.req", 32'(mem_req), 32'd0);
        check("rst.be", 32'(mem_be), 32'd0);
        check("rst.addr", mem_addr, 32'h0);
        check("rst.wdata", mem_wdata, 32'h0);
        check("rst.misalign", 32'(misalign), 32'd0);
        check("rst.bus_err", 32'(bus_err), 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.ctl", 32'(control_MEM), 32'd0);
        reset = 1'b1;

        // Reset asserted mid-BUSY clears the bus without a clock edge.
        ack_en = 1'b0;
        @(posedge clock); #1;
        valid_EX = 1'b1; control_EX = 8'h29; alu_result = 32'h500; rd = 5'd3;
        repeat (3) @(negedge clock);
        check("arst.req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0; valid_EX = 1'b0; control_EX = 8'h00;
        #1;
        check("arst.req", 32'(mem_req), 32'd0);
        check("arst.stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Non-memory op passes straight through.
        @(posedge clock); #1;
        valid_EX = 1'b1; control_EX = 8'h04; alu_result = 32'h7; rd = 5'd5;
        #1;
        check("pass.d2", d2, 32'h7);
        check("pass.rd", 32'(rd_MEM), 32'd5);
        check("pass.ctl", 32'(control_MEM), 32'h04);
        check("pass.stall", 32'(stall), 32'd0);
        go_idle();

        // Signed byte load, top lane.
        mem_op("lb_s", 8'h49, 32'h103, 32'h0, 32'h80123456, 0, 32'hFFFF_FF80, 4'h0, 32'h0);
        go_idle();

        // Halfword store, upper half.
        mem_op("sh", 8'h12, 32'h102, 32'h1234_ABCD, 32'h0, 0, 32'h102, 4'b1100, 32'hABCD_ABCD);
        go_idle();

        // Misaligned word load is dropped.
        req0 = req_count;
        @(posedge clock); #1;
        valid_EX = 1'b1; control_EX = 8'h29; alu_result = 32'h201; rd = 5'd9;
        @(negedge clock);
        check("mis.stall", 32'(stall), 32'd0);
        check("mis.ctl", 32'(control_MEM), 32'd0);
        check("mis.pulse_early", 32'(misalign), 32'd0);
        go_idle();
        @(negedge clock);
        check("mis.pulse", 32'(misalign), 32'd1);
        check("mis.req", 32'(mem_req), 32'd0);
        @(negedge clock);
        check("mis.pulse_end", 32'(misalign), 32'd0);
        check("mis.req_count", 32'(req_count - req0), 32'd0);

        // Timeout, then ack on the very last BUSY cycle.
        mem_op("to", 8'h2D, 32'h300, 32'h0, 32'hDEAD_BEEF, -1, 32'h0, 4'h0, 32'h0);
        go_idle();
        @(negedge clock);
        check("to.bus_err_end", 32'(bus_err), 32'd0);
        mem_op("to_last", 8'h2D, 32'h304, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1,
               32'hCAFE_F00D, 4'h0, 32'h0);
        go_idle();

        // Back-to-back loads, three wait cycles each.
        mem_op("b2b_lhu", 8'h1D, 32'h402, 32'h0, 32'hF00D_BEEF, 3, 32'h0000_F00D, 4'h0, 32'h0);
        mem_op("b2b_lh",  8'h5D, 32'h404, 32'h0, 32'h1234_8001, 3, 32'hFFFF_8001, 4'h0, 32'h0);
        mem_op("b2b_lbu", 8'h0D, 32'h405, 32'h0, 32'hAABB_CCDD, 3, 32'h0000_00CC, 4'h0, 32'h0);
        go_idle();

        // Random aligned loads and stores.
        for (int i = 0; i < 10; i++) begin
            sz  = 2'($urandom_range(0, 3));
            st  = 1'($urandom_range(0, 1));
            o   = 2'($urandom_range(0, 3));
            if (sz == 2'b01) o[0] = 1'b0;
            if (sz[1]) o = 2'b00;
            addr = {$urandom_range(0, 32'hFFFF), 14'h0, o};
            sd   = $urandom;
            rdv  = $urandom;
            w    = $urandom_range(0, 4);
            if (st) ctl = {2'b00, sz, 4'b0010};
            else    ctl = {1'b0, 1'($urandom_range(0, 1)), sz, 4'b1101};
            mem_op("rnd", ctl, addr, sd, rdv, w,
                   st ? addr : model_load(rdv, o, ctl),
                   st ? model_be(o, ctl) : 4'h0, model_wdata(sd, ctl));
        end
        go_idle();
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
